// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Multi-precision (32*WORDS-bit) add/subtract that time-shares a single
//   32-bit ripple-carry adder. One limb is processed per clock, least
//   significant limb first, and the carry is registered between beats.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request pulse, only sampled in IDLE
//   sub     0: a+b, 1: a-b (sampled with start)
//   a, b    W-bit operands (sampled with start)
//   busy    high while in RUN or DONE
//   done    one-cycle completion pulse
//   result  W-bit sum/difference register
//   cout    final carry out (for sub: 1 means no borrow, a >= b unsigned)
//   ovf     two's-complement signed overflow of the W-bit operation

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// 32-bit ripple chain built from an array of full-adder cells.
module ripple_carry_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  full_adder u_fa [31:0] (
    .a  (a),
    .b  (b),
    .ci (c[31:0]),
    .s  (sum),
    .co (c[32:1])
  );

  assign cout = c[32];
endmodule

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);
  localparam int IW = $clog2(WORDS) + 1;
  // limb select width; idx carries one extra bit so it can count to WORDS
  localparam int SW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic                  sub;
    logic [WORDS-1:0][31:0] a;
    logic [WORDS-1:0][31:0] b;
  } req_t;

  state_t                 state, nstate;
  req_t                   req_q;
  logic [IW-1:0]          idx;
  logic [SW-1:0]          sel;
  logic                   c;
  logic [WORDS-1:0][31:0] res_q;

  logic [31:0]            a_limb, b_limb, sum;
  logic                   add_co;
  logic                   last;

  assign sel    = idx[SW-1:0];
  assign last   = (idx == IW'(WORDS - 1));
  assign a_limb = req_q.a[sel];
  // subtraction is a + ~b + 1; the +1 enters as the initial carry
  assign b_limb = req_q.b[sel] ^ {32{req_q.sub}};

  ripple_carry_adder_32bit u_add (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (c),
    .sum  (sum),
    .cout (add_co)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  assign result = res_q;

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      idx   <= '0;
      c     <= 1'b0;
      res_q <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_q <= {sub, a, b};
            idx   <= '0;
            c     <= sub;
          end
        end
        RUN: begin
          res_q[sel] <= sum;
          c          <= add_co;
          idx        <= idx + 1'b1;
          if (last) begin
            cout <= add_co;
            // signed overflow: like-signed inputs to the top limb, unlike-signed sum
            ovf  <= (a_limb[31] == b_limb[31]) && (sum[31] != a_limb[31]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model using full-width arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t       e;
    logic [W:0] t;
    if (s) begin
      e.res  = x - y;
      e.cout = (x >= y);
      e.ovf  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    end else begin
      t      = {1'b0, x} + {1'b0, y};
      e.res  = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    end
    return e;
  endfunction

  // Called at the negedge right after the accepting edge (start already low).
  task automatic finish_op(input string tag);
    int   n;
    int   nb;
    exp_t e;
    n  = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    chk({tag, " done seen"}, W'(done), W'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (done) begin
        chk({tag, " latency"}, W'(n), W'(WORDS + 1));
        chk({tag, " busy cycles"}, W'(nb), W'(WORDS + 1));
        chk({tag, " result"}, result, e.res);
        chk({tag, " cout"}, W'(cout), W'(e.cout));
        chk({tag, " ovf"}, W'(ovf), W'(e.ovf));
      end
    end
    @(negedge clk);
    chk({tag, " done pulse width"}, W'(done), W'(0));
    chk({tag, " busy after"}, W'(busy), W'(0));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input string tag);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    sbq.push_back(model(x, y, s));
    @(negedge clk);
    start = 1'b0;
    a = rnd(); b = rnd(); sub = 1'($urandom);
    finish_op(tag);
  endtask

  localparam int NV = 14;
  vec_t vt[NV];

  initial begin
    logic [W-1:0] ones, msb, lsb1;
    int           n, pulses;
    exp_t         e;

    ones = '1;
    msb  = '0; msb[W-1] = 1'b1;
    lsb1 = W'(1);

    vt[0] = '{a: ones,            b: lsb1,           sub: 1'b0, res: '0,                 cout: 1'b1, ovf: 1'b0};
    vt[1] = '{a: '0,              b: lsb1,           sub: 1'b1, res: ones,               cout: 1'b0, ovf: 1'b0};
    vt[2] = '{a: W'(5),           b: W'(3),          sub: 1'b1, res: W'(2),              cout: 1'b1, ovf: 1'b0};
    vt[3] = '{a: ~msb,            b: lsb1,           sub: 1'b0, res: msb,                cout: 1'b0, ovf: 1'b1};
    vt[4] = '{a: msb,             b: lsb1,           sub: 1'b1, res: ~msb,               cout: 1'b1, ovf: 1'b1};
    vt[5] = '{a: W'(64'hFFFF_FFFF), b: lsb1,         sub: 1'b0, res: W'(64'h1_0000_0000), cout: 1'b0, ovf: 1'b0};
    vt[6] = '{a: msb,             b: msb,            sub: 1'b0, res: '0,                 cout: 1'b1, ovf: 1'b1};
    vt[7] = '{a: W'(7),           b: W'(7),          sub: 1'b1, res: '0,                 cout: 1'b1, ovf: 1'b0};
    for (int i = 8; i < NV; i++) begin
      vt[i].a   = rnd();
      vt[i].b   = rnd();
      vt[i].sub = 1'(i & 1);
      e = model(vt[i].a, vt[i].b, vt[i].sub);
      vt[i].res  = e.res;
      vt[i].cout = e.cout;
      vt[i].ovf  = e.ovf;
    end

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom); sub = 1'($urandom); a = rnd(); b = rnd();
    end
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset result", result, '0);
    chk("reset cout", W'(cout), W'(0));
    chk("reset ovf", W'(ovf), W'(0));
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a = vt[i].a; b = vt[i].b; sub = vt[i].sub; start = 1'b1;
      sbq.push_back('{res: vt[i].res, cout: vt[i].cout, ovf: vt[i].ovf});
      @(negedge clk);
      start = 1'b0;
      a = rnd(); b = rnd(); sub = 1'($urandom);
      finish_op($sformatf("vec%0d", i));
    end

    // Handshake: start held through RUN/DONE with changing operands
    @(negedge clk);
    a = W'(64'h1234_5678_9ABC_DEF0); b = W'(64'h0FED_CBA9_8765_4321); sub = 1'b0; start = 1'b1;
    sbq.push_back(model(a, b, 1'b0));
    n = 0; pulses = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) begin pulses++; break; end
      a = rnd(); b = rnd(); sub = 1'($urandom);
    end
    chk("hold latency", W'(n), W'(WORDS + 1));
    chk("hold done pulses", W'(pulses), W'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("hold result", result, e.res);
      chk("hold cout", W'(cout), W'(e.cout));
    end
    // Second op presented during DONE, still held into the following IDLE cycle
    a = rnd(); b = rnd(); sub = 1'b1;
    sbq.push_back(model(a, b, 1'b1));
    @(negedge clk);
    chk("hold idle gap", W'(busy), W'(0));
    @(negedge clk);
    start = 1'b0;
    chk("hold restart accepted", W'(busy), W'(1));
    finish_op("hold op2");

    // Reset mid-operation, asserted between clock edges after limb 2 is written
    @(negedge clk);
    a = ones; b = rnd(); sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", W'(busy), W'(0));
    chk("async rst result", result, '0);
    chk("async rst cout", W'(cout), W'(0));
    chk("async rst ovf", W'(ovf), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (WORDS + 4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abandoned op done", W'(pulses), W'(0));
    chk("abandoned op result", result, '0);
    run_op(W'(64'h1_0000_0000), W'(64'hFFFF_FFFF), 1'b0, "post-reset");
    chk("post-reset literal", result, W'(64'h1_FFFF_FFFF));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
